// File: rtl/frame_fetch_ctrl_if.sv
// Bus bundle between frame_fetch_ctrl and its neighbours: frame control, loader write port,
// pixel stream to the LED serializer and the SPRAM port.
interface frame_fetch_ctrl_if;
   logic        frame_start;
   logic        wr_req;
   logic [13:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic [23:0] pix_rgb;
   logic        pix_valid;
   logic        pix_ready;
   logic        frame_done;
   logic        busy;
   logic [13:0] spram_addr;
   logic [15:0] spram_di;
   logic        spram_we;
   logic [15:0] spram_do;

   modport master (
      input  frame_start, wr_req, wr_addr, wr_data, pix_ready, spram_do,
      output wr_ack, pix_rgb, pix_valid, frame_done, busy, spram_addr, spram_di, spram_we
   );

   modport slave (
      output frame_start, wr_req, wr_addr, wr_data, pix_ready, spram_do,
      input  wr_ack, pix_rgb, pix_valid, frame_done, busy, spram_addr, spram_di, spram_we
   );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// Streams a frame of 24-bit pixels from single-port SPRAM to the LED serializer and
// arbitrates the shared SPRAM port with the pixel loader's write requests.
module frame_fetch_ctrl #(
   parameter int unsigned NUM_LEDS  = 8,
   parameter logic [13:0] BASE_ADDR = 14'd0
) (
   input logic              clk,
   input logic              rst_n,
   frame_fetch_ctrl_if.master bus
);

   localparam int unsigned    IdxW    = $clog2(NUM_LEDS) + 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LEDS - 1);

   typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StCapt, StPresent, StDone} state_e;

   state_e          state_q;
   logic [IdxW-1:0] idx_q;
   logic            pending_start_q;
   logic [23:0]     pix_rgb_q;
   logic            pix_valid_q;
   logic            frame_done_q;

   logic [13:0] lo_addr;
   logic        wr_grant;

   assign lo_addr = BASE_ADDR + 14'({idx_q, 1'b0});

   // A pending frame start outranks the loader so a deferred frame cannot starve.
   assign wr_grant = bus.wr_req &
                     (((state_q == StIdle) & ~pending_start_q) | (state_q == StPresent));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         idx_q           <= '0;
         pending_start_q <= 1'b0;
         pix_rgb_q       <= '0;
         pix_valid_q     <= 1'b0;
         frame_done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wr_grant) begin
                  if (bus.frame_start) pending_start_q <= 1'b1;
               end else if (bus.frame_start || pending_start_q) begin
                  state_q         <= StRdLo;
                  idx_q           <= '0;
                  pending_start_q <= 1'b0;
               end
            end
            StRdLo: state_q <= StRdHi;
            StRdHi: begin
               pix_rgb_q[15:0] <= bus.spram_do;
               state_q         <= StCapt;
            end
            StCapt: begin
               pix_rgb_q[23:16] <= bus.spram_do[7:0];
               pix_valid_q      <= 1'b1;
               state_q          <= StPresent;
            end
            StPresent: begin
               if (bus.pix_ready) begin
                  pix_valid_q <= 1'b0;
                  if (idx_q == LastIdx) begin
                     frame_done_q <= 1'b1;
                     state_q      <= StDone;
                  end else begin
                     idx_q   <= idx_q + IdxW'(1);
                     state_q <= StRdLo;
                  end
               end
            end
            StDone: begin
               frame_done_q <= 1'b0;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      bus.spram_addr = '0;
      bus.spram_di   = '0;
      bus.spram_we   = 1'b0;
      bus.wr_ack     = 1'b0;
      if (wr_grant) begin
         bus.spram_addr = bus.wr_addr;
         bus.spram_di   = bus.wr_data;
         bus.spram_we   = 1'b1;
         bus.wr_ack     = 1'b1;
      end else if (state_q == StRdLo) begin
         bus.spram_addr = lo_addr;
      end else if (state_q == StRdHi) begin
         bus.spram_addr = lo_addr + 14'd1;
      end
   end

   assign bus.pix_rgb    = pix_rgb_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = (state_q != StIdle) | pending_start_q;

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// Directed bench for frame_fetch_ctrl: a cycle table for a two-pixel frame plus hand-written
// sequences for stalls, write arbitration, deferred start, top-of-memory base and reset.
module tb_frame_fetch_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   passes;

   frame_fetch_ctrl_if a ();
   frame_fetch_ctrl_if b ();

   frame_fetch_ctrl #(.NUM_LEDS(2), .BASE_ADDR(14'h0000)) dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (a)
   );

   frame_fetch_ctrl #(.NUM_LEDS(2), .BASE_ADDR(14'h3FFC)) dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (b)
   );

   // Behavioural SPRAM: one-cycle registered read, write on WE.
   logic [15:0] mem_a [16384];
   logic [15:0] mem_b [16384];

   always @(posedge clk) begin
      if (a.spram_we) mem_a[a.spram_addr] <= a.spram_di;
      a.spram_do <= mem_a[a.spram_addr];
   end

   always @(posedge clk) begin
      if (b.spram_we) mem_b[b.spram_addr] <= b.spram_di;
      b.spram_do <= mem_b[b.spram_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   typedef struct {
      logic        fs;
      logic        wr;
      logic [13:0] wa;
      logic [15:0] wd;
      logic        rdy;
      logic        e_ack;
      logic        e_we;
      logic [13:0] e_addr;
      logic        e_valid;
      logic [23:0] e_rgb;
      logic        e_done;
      logic        e_busy;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic drive(input logic fs, input logic wr, input logic [13:0] wa,
                        input logic [15:0] wd, input logic rdy);
      @(negedge clk);
      a.frame_start = fs;
      a.wr_req      = wr;
      a.wr_addr     = wa;
      a.wr_data     = wd;
      a.pix_ready   = rdy;
      #1;
   endtask

   task automatic drive_b(input logic fs, input logic wr, input logic [13:0] wa,
                          input logic [15:0] wd, input logic rdy);
      @(negedge clk);
      b.frame_start = fs;
      b.wr_req      = wr;
      b.wr_addr     = wa;
      b.wr_data     = wd;
      b.pix_ready   = rdy;
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " valid"}, 24'(a.pix_valid), 24'h0);
      chk({tag, " rgb"}, a.pix_rgb, 24'h0);
      chk({tag, " done"}, 24'(a.frame_done), 24'h0);
      chk({tag, " busy"}, 24'(a.busy), 24'h0);
      chk({tag, " ack"}, 24'(a.wr_ack), 24'h0);
      chk({tag, " we"}, 24'(a.spram_we), 24'h0);
      chk({tag, " addr"}, 24'(a.spram_addr), 24'h0);
      chk({tag, " di"}, 24'(a.spram_di), 24'h0);
   endtask

   initial begin
      checks = 0;
      passes = 0;
      rst_n  = 1'b0;
      a.frame_start = 0; a.wr_req = 0; a.wr_addr = 0; a.wr_data = 0; a.pix_ready = 0;
      b.frame_start = 0; b.wr_req = 0; b.wr_addr = 0; b.wr_data = 0; b.pix_ready = 0;

      //          fs    wr    wa      wd        rdy   ack   we    addr    vld   rgb         dn    busy
      vt[0]  = '{1'b0, 1'b1, 14'h0, 16'hCEFF, 1'b0, 1'b1, 1'b1, 14'h0, 1'b0, 24'h000000, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 14'h1, 16'h0000, 1'b0, 1'b1, 1'b1, 14'h1, 1'b0, 24'h000000, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 14'h2, 16'h1234, 1'b0, 1'b1, 1'b1, 14'h2, 1'b0, 24'h000000, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 14'h3, 16'h0056, 1'b0, 1'b1, 1'b1, 14'h3, 1'b0, 24'h000000, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 24'h000000, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 24'h000000, 1'b0, 1'b1};
      vt[6]  = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h1, 1'b0, 24'h000000, 1'b0, 1'b1};
      vt[7]  = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 24'h00CEFF, 1'b0, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b1, 24'h00CEFF, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h2, 1'b0, 24'h00CEFF, 1'b0, 1'b1};
      vt[10] = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h3, 1'b0, 24'h00CEFF, 1'b0, 1'b1};
      vt[11] = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 24'h001234, 1'b0, 1'b1};
      vt[12] = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b1, 24'h561234, 1'b0, 1'b1};
      vt[13] = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 24'h561234, 1'b1, 1'b1};
      vt[14] = '{1'b0, 1'b0, 14'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 24'h561234, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      #1;
      chk_zero("reset");
      chk("reset b busy", 24'(b.busy), 24'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load two pixels and stream them with pix_ready tied high.
      for (int i = 0; i < 15; i++) begin
         drive(vt[i].fs, vt[i].wr, vt[i].wa, vt[i].wd, vt[i].rdy);
         chk($sformatf("vec%0d ack", i), 24'(a.wr_ack), 24'(vt[i].e_ack));
         chk($sformatf("vec%0d we", i), 24'(a.spram_we), 24'(vt[i].e_we));
         chk($sformatf("vec%0d addr", i), 24'(a.spram_addr), 24'(vt[i].e_addr));
         chk($sformatf("vec%0d di", i), 24'(a.spram_di), vt[i].e_we ? 24'(vt[i].wd) : 24'h0);
         chk($sformatf("vec%0d valid", i), 24'(a.pix_valid), 24'(vt[i].e_valid));
         chk($sformatf("vec%0d rgb", i), a.pix_rgb, vt[i].e_rgb);
         chk($sformatf("vec%0d done", i), 24'(a.frame_done), 24'(vt[i].e_done));
         chk($sformatf("vec%0d busy", i), 24'(a.busy), 24'(vt[i].e_busy));
      end

      // Stall in PRESENT for 20 cycles, then overwrite pixel 1's upper byte before it is fetched.
      drive(1, 0, 0, 0, 0);
      repeat (3) drive(0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         drive(0, 0, 0, 0, 0);
         chk($sformatf("stall%0d valid", k), 24'(a.pix_valid), 24'h1);
         chk($sformatf("stall%0d rgb", k), a.pix_rgb, 24'h00CEFF);
         chk($sformatf("stall%0d we", k), 24'(a.spram_we), 24'h0);
         chk($sformatf("stall%0d addr", k), 24'(a.spram_addr), 24'h0);
      end
      drive(0, 1, 14'h3, 16'h0077, 0);
      chk("stall wr ack", 24'(a.wr_ack), 24'h1);
      chk("stall wr we", 24'(a.spram_we), 24'h1);
      chk("stall wr addr", 24'(a.spram_addr), 24'h3);
      chk("stall wr di", 24'(a.spram_di), 24'h0077);
      chk("stall wr valid", 24'(a.pix_valid), 24'h1);
      drive(0, 0, 0, 0, 1);
      chk("stall hs valid", 24'(a.pix_valid), 24'h1);
      repeat (3) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      chk("stall px1 valid", 24'(a.pix_valid), 24'h1);
      chk("stall px1 rgb", a.pix_rgb, 24'h771234);
      drive(0, 0, 0, 0, 1);
      chk("stall done", 24'(a.frame_done), 24'h1);
      drive(0, 0, 0, 0, 1);
      chk("stall idle busy", 24'(a.busy), 24'h0);

      // Write request raised during the read phase waits for PRESENT.
      drive(1, 0, 0, 0, 1);
      drive(0, 1, 14'h5, 16'hABCD, 1);
      chk("rdwr c1 ack", 24'(a.wr_ack), 24'h0);
      chk("rdwr c1 we", 24'(a.spram_we), 24'h0);
      drive(0, 1, 14'h5, 16'hABCD, 1);
      chk("rdwr c2 ack", 24'(a.wr_ack), 24'h0);
      chk("rdwr c2 addr", 24'(a.spram_addr), 24'h1);
      drive(0, 1, 14'h5, 16'hABCD, 1);
      chk("rdwr c3 ack", 24'(a.wr_ack), 24'h0);
      chk("rdwr c3 we", 24'(a.spram_we), 24'h0);
      drive(0, 1, 14'h5, 16'hABCD, 1);
      chk("rdwr c4 ack", 24'(a.wr_ack), 24'h1);
      chk("rdwr c4 we", 24'(a.spram_we), 24'h1);
      chk("rdwr c4 addr", 24'(a.spram_addr), 24'h5);
      chk("rdwr c4 di", 24'(a.spram_di), 24'hABCD);
      chk("rdwr c4 valid", 24'(a.pix_valid), 24'h1);
      repeat (3) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      chk("rdwr c8 rgb", a.pix_rgb, 24'h771234);
      drive(0, 0, 0, 0, 1);
      chk("rdwr c9 done", 24'(a.frame_done), 24'h1);
      drive(0, 0, 0, 0, 1);
      chk("rdwr c10 busy", 24'(a.busy), 24'h0);

      // frame_start and wr_req together: write first, frame deferred by one cycle.
      drive(1, 1, 14'h4, 16'h1111, 1);
      chk("pend c0 ack", 24'(a.wr_ack), 24'h1);
      chk("pend c0 addr", 24'(a.spram_addr), 24'h4);
      drive(0, 1, 14'h4, 16'h1111, 1);
      chk("pend c1 ack", 24'(a.wr_ack), 24'h0);
      chk("pend c1 busy", 24'(a.busy), 24'h1);
      drive(0, 1, 14'h4, 16'h1111, 1);
      chk("pend c2 ack", 24'(a.wr_ack), 24'h0);
      chk("pend c2 busy", 24'(a.busy), 24'h1);
      drive(0, 0, 0, 0, 1);
      chk("pend c3 addr", 24'(a.spram_addr), 24'h1);
      drive(0, 0, 0, 0, 1);
      chk("pend c4 valid", 24'(a.pix_valid), 24'h0);
      drive(0, 0, 0, 0, 1);
      chk("pend c5 valid", 24'(a.pix_valid), 24'h1);
      chk("pend c5 rgb", a.pix_rgb, 24'h00CEFF);
      repeat (3) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      chk("pend c9 rgb", a.pix_rgb, 24'h771234);
      drive(0, 0, 0, 0, 1);
      chk("pend c10 done", 24'(a.frame_done), 24'h1);
      drive(0, 0, 0, 0, 1);
      chk("pend c11 busy", 24'(a.busy), 24'h0);

      // Base at the top of SPRAM: reads 3FFC..3FFF, upper byte of odd words ignored.
      drive_b(0, 1, 14'h3FFC, 16'hBEEF, 1);
      drive_b(0, 1, 14'h3FFD, 16'h00AD, 1);
      drive_b(0, 1, 14'h3FFE, 16'h5A5A, 1);
      drive_b(0, 1, 14'h3FFF, 16'hFFC3, 1);
      drive_b(1, 0, 0, 0, 1);
      drive_b(0, 0, 0, 0, 1);
      chk("top c1 addr", 24'(b.spram_addr), 24'h3FFC);
      drive_b(0, 0, 0, 0, 1);
      chk("top c2 addr", 24'(b.spram_addr), 24'h3FFD);
      drive_b(0, 0, 0, 0, 1);
      drive_b(0, 0, 0, 0, 1);
      chk("top c4 rgb", b.pix_rgb, 24'hADBEEF);
      drive_b(0, 0, 0, 0, 1);
      chk("top c5 addr", 24'(b.spram_addr), 24'h3FFE);
      drive_b(0, 0, 0, 0, 1);
      chk("top c6 addr", 24'(b.spram_addr), 24'h3FFF);
      drive_b(0, 0, 0, 0, 1);
      drive_b(0, 0, 0, 0, 1);
      chk("top c8 rgb", b.pix_rgb, 24'hC35A5A);
      drive_b(0, 0, 0, 0, 1);
      chk("top c9 done", 24'(b.frame_done), 24'h1);

      // Reset while fetching pixel 1 (RD_HI), then restart from pixel 0.
      drive(1, 0, 0, 0, 1);
      repeat (5) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      chk("rst pre addr", 24'(a.spram_addr), 24'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 1);
      chk("post rst busy", 24'(a.busy), 24'h0);
      drive(1, 0, 0, 0, 1);
      repeat (3) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      chk("post rst valid", 24'(a.pix_valid), 24'h1);
      chk("post rst rgb", a.pix_rgb, 24'h00CEFF);
      repeat (3) drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      chk("post rst px1", a.pix_rgb, 24'h771234);
      drive(0, 0, 0, 0, 1);
      chk("post rst done", 24'(a.frame_done), 24'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
